// File: rtl/ccff_chain_programmer.sv
// Host-side configuration-chain loader: serialises bitstream words onto
// ccff_head and returns the bits leaving ccff_tail as readback words.
module ccff_chain_programmer #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IW-1:0]    IDX_LAST = IW'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IW-1:0]     rb_idx_q, rb_idx_d;
    logic [WORD_W-1:0] rb_shift_q, rb_shift_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    logic              stall;
    logic              fire;
    logic [WORD_W-1:0] rb_word;

    // Hold the chain only when a completed word would overwrite one still pending
    assign stall = rb_valid_q && !rb_ready && (rb_idx_q == IDX_LAST);
    assign fire  = (state_q == S_SHIFT) && !stall;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            word_q     <= '0;
            rb_idx_q   <= '0;
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            word_q     <= word_d;
            rb_idx_q   <= rb_idx_d;
            rb_shift_q <= rb_shift_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        word_d     = word_q;
        rb_idx_d   = rb_idx_q;
        rb_shift_d = rb_shift_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = rb_valid_q && !rb_ready;
        rb_word    = rb_shift_q;
        rb_word[rb_idx_q] = ccff_tail;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    rb_idx_d   = '0;
                    rb_shift_d = '0;
                end
            end
            S_FETCH: begin
                if (bs_valid) begin
                    word_d    = bs_data;
                    bit_idx_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (rb_idx_q == IDX_LAST) begin
                        rb_data_d  = rb_word;
                        rb_valid_d = 1'b1;
                        rb_shift_d = '0;
                        rb_idx_d   = '0;
                    end else begin
                        rb_shift_d = rb_word;
                        rb_idx_d   = rb_idx_q + IW'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FLUSH;
                    end else if (bit_idx_q == IDX_LAST) begin
                        state_d = S_FETCH;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Upper bits of the partial word are already zero
                if (!rb_valid_q || rb_ready) begin
                    if (rb_idx_q != '0) begin
                        rb_data_d  = rb_shift_q;
                        rb_valid_d = 1'b1;
                        rb_idx_d   = '0;
                        rb_shift_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bs_ready      = (state_q == S_FETCH);
    assign ccff_shift_en = fire;
    assign ccff_head     = (state_q == S_SHIFT) && word_q[bit_idx_q];
    assign rb_data       = rb_data_q;
    assign rb_valid      = rb_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Bench for ccff_chain_programmer: three chain lengths (8, 10, 20) against a
// behavioural chain model, with head-bit and readback scoreboards.
module tb_ccff_chain_programmer;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic [2:0] start;
    logic [7:0] bs_data;
    logic       bs_valid;
    logic       rb_rdy;
    logic [2:0] tail, bs_ready, head, sen, rb_valid, busy, done;
    logic [7:0] rb_data [3];

    always #5 prog_clk = ~prog_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ccff_chain_programmer #(
            .CHAIN_LEN(g == 0 ? 8 : (g == 1 ? 10 : 20)),
            .WORD_W(8),
            .CNT_W(16)
        ) u_dut (
            .prog_clk     (prog_clk),
            .prog_reset_n (prog_reset_n),
            .start        (start[g]),
            .bs_data      (bs_data),
            .bs_valid     (bs_valid),
            .bs_ready     (bs_ready[g]),
            .ccff_head    (head[g]),
            .ccff_shift_en(sen[g]),
            .ccff_tail    (tail[g]),
            .rb_data      (rb_data[g]),
            .rb_valid     (rb_valid[g]),
            .rb_ready     (rb_rdy),
            .busy         (busy[g]),
            .done         (done[g])
        );
    end

    typedef struct {
        int          k;
        logic [31:0] pre;
        int          nw;
        logic [7:0]  w0, w1, w2;
        logic [31:0] ec;
        int          ew;
    } vec_t;

    int nchk = 0;
    int nfail = 0;
    int act = 0;
    int cur_len = 8;
    int q_bits = 0;
    int n_shift = 0;
    int n_words = 0;
    int s0, wd0;

    logic [7:0]  feed[$];
    logic        exp_head[$];
    logic [7:0]  exp_rb[$];
    logic [31:0] chain[3];
    logic [31:0] pre_val[3];
    logic [2:0]  pre_req;

    function automatic int len_of(int k);
        return (k == 0) ? 8 : ((k == 1) ? 10 : 20);
    endfunction

    function automatic vec_t mk(int k, logic [31:0] pre, int nw,
                                logic [7:0] w0, logic [7:0] w1,
                                logic [7:0] w2, logic [31:0] ec, int ew);
        vec_t v;
        v.k = k; v.pre = pre; v.nw = nw;
        v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.ec = ec; v.ew = ew;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, a, e);
        end
    endtask

    // Chain model, scoreboards and bitstream feeder
    initial begin
        logic        hs;
        logic [31:0] nxt[3];
        logic [31:0] t;
        for (int k = 0; k < 3; k++) begin
            chain[k] = '0;
            tail[k]  = 1'b0;
        end
        bs_valid = 1'b0;
        bs_data  = 8'h00;
        forever begin
            @(negedge prog_clk);
            hs = bs_valid && bs_ready[act];
            if (hs) n_words++;
            if (sen[act]) begin
                n_shift++;
                if (exp_head.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL head_extra: got unexpected shift, required none");
                end else begin
                    check("head", head[act], exp_head.pop_front());
                end
            end
            if (rb_valid[act] && rb_rdy) begin
                if (exp_rb.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL rb_extra: got word 0x%0h, required none",
                             rb_data[act]);
                end else begin
                    check("rb_data", rb_data[act], exp_rb.pop_front());
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (sen[k]) check("sen_busy", busy[k], 1);
                nxt[k] = chain[k];
                if (sen[k]) begin
                    t = chain[k] >> 1;
                    t[len_of(k)-1] = head[k];
                    nxt[k] = t;
                end
            end
            @(posedge prog_clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                chain[k] = pre_req[k] ? pre_val[k] : nxt[k];
                tail[k]  = chain[k][0];
            end
            if (hs && feed.size() > 0) void'(feed.pop_front());
            bs_valid = (feed.size() > 0);
            bs_data  = (feed.size() > 0) ? feed[0] : 8'h00;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic prep(int k, logic [31:0] pre);
        logic [7:0] w;
        act = k;
        cur_len = len_of(k);
        q_bits = 0;
        pre_val[k] = pre;
        pre_req[k] = 1'b1;
        cyc();
        cyc();
        pre_req[k] = 1'b0;
        w = '0;
        for (int i = 0; i < cur_len; i++) begin
            w[i % 8] = pre[i];
            if ((i % 8) == 7 || i == cur_len - 1) begin
                exp_rb.push_back(w);
                w = '0;
            end
        end
        s0 = n_shift;
        wd0 = n_words;
    endtask

    task automatic queue_word(logic [7:0] w);
        feed.push_back(w);
        for (int i = 0; i < 8; i++) begin
            if (q_bits < cur_len) begin
                exp_head.push_back(w[i]);
                q_bits++;
            end
        end
    endtask

    task automatic pulse_start(bit chk);
        cyc();
        start[act] = 1'b1;
        cyc();
        start[act] = 1'b0;
        if (chk) begin
            @(negedge prog_clk);
            #1;
            check("busy_after_start", busy[act], 1);
        end
    endtask

    task automatic wait_done(int limit);
        bit got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge prog_clk);
            #1;
            if (done[act]) got = 1'b1;
        end
        if (!got) begin
            nchk++; nfail++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done",
                     limit);
        end else begin
            @(negedge prog_clk);
            #1;
            check("done_pulse", done[act], 0);
            check("idle_after", busy[act], 0);
        end
    endtask

    task automatic finish_load(logic [31:0] ec, int ew);
        check("shifts", n_shift - s0, cur_len);
        check("words", n_words - wd0, ew);
        check("chain", chain[act], ec);
        check("head_left", exp_head.size(), 0);
        check("rb_left", exp_rb.size(), 0);
    endtask

    task automatic chk_reset(int k);
        check("rst_bs_ready", bs_ready[k], 0);
        check("rst_head", head[k], 0);
        check("rst_shift_en", sen[k], 0);
        check("rst_rb_valid", rb_valid[k], 0);
        check("rst_rb_data", rb_data[k], 0);
        check("rst_busy", busy[k], 0);
        check("rst_done", done[k], 0);
    endtask

    initial begin
        vec_t tbl[4];
        bit   seen;
        pre_req = '0;
        start = '0;
        rb_rdy = 1'b1;
        prog_reset_n = 1'b0;

        tbl[0] = mk(0, 32'hA5, 1, 8'h3C, 8'h00, 8'h00, 32'h3C, 1);
        tbl[1] = mk(1, 32'h155, 2, 8'hFF, 8'h02, 8'h00, 32'h2FF, 2);
        tbl[2] = mk(1, 32'h2FF, 2, 8'h00, 8'hFE, 8'h00, 32'h200, 2);
        tbl[3] = mk(2, 32'hFFFFF, 3, 8'hA5, 8'h5A, 8'hFC, 32'hC5AA5, 3);

        #12;
        for (int k = 0; k < 3; k++) chk_reset(k);
        cyc();
        prog_reset_n = 1'b1;

        for (int n = 0; n < 4; n++) begin
            prep(tbl[n].k, tbl[n].pre);
            queue_word(tbl[n].w0);
            if (tbl[n].nw > 1) queue_word(tbl[n].w1);
            if (tbl[n].nw > 2) queue_word(tbl[n].w2);
            pulse_start(1'b1);
            wait_done(300);
            finish_load(tbl[n].ec, tbl[n].ew);
        end

        // Input gap between words
        prep(1, 32'h0F0);
        queue_word(8'hFF);
        pulse_start(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge prog_clk);
            #1;
            if (bs_ready[1] && !bs_valid && (n_words - wd0) == 1) seen = 1'b1;
        end
        check("gap_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            check("gap_shift_en", sen[1], 0);
            @(negedge prog_clk);
            #1;
        end
        queue_word(8'h02);
        wait_done(300);
        finish_load(32'h2FF, 2);

        // Readback back-pressure while the second word completes
        cyc();
        rb_rdy = 1'b0;
        prep(2, 32'hABCDE);
        queue_word(8'h12);
        queue_word(8'h34);
        queue_word(8'h05);
        pulse_start(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge prog_clk);
            #1;
            if ((n_shift - s0) >= 15 && rb_valid[2] && !sen[2]) seen = 1'b1;
        end
        check("stall_seen", seen, 1);
        for (int i = 0; i < 4; i++) begin
            check("stall_shift_en", sen[2], 0);
            check("stall_rb_data", rb_data[2], 8'hDE);
            check("stall_shifts", n_shift - s0, 15);
            @(negedge prog_clk);
            #1;
        end
        cyc();
        rb_rdy = 1'b1;
        wait_done(300);
        finish_load(32'h53412, 3);

        // start while busy
        prep(1, 32'h123);
        queue_word(8'hC3);
        queue_word(8'h02);
        pulse_start(1'b1);
        repeat (4) cyc();
        pulse_start(1'b0);
        wait_done(300);
        finish_load(32'h2C3, 2);
        repeat (3) cyc();
        check("no_restart", busy[1], 0);

        // Reset in the middle of a load
        prep(1, 32'h3FF);
        queue_word(8'h00);
        queue_word(8'h01);
        pulse_start(1'b1);
        for (int i = 0; i < 100 && (n_shift - s0) < 3; i++) begin
            @(negedge prog_clk);
            #1;
        end
        check("rst_shift3", n_shift - s0, 3);
        @(posedge prog_clk);
        #2;
        prog_reset_n = 1'b0;
        #1;
        chk_reset(1);
        feed.delete();
        exp_head.delete();
        exp_rb.delete();
        cyc();
        prog_reset_n = 1'b1;
        prep(1, 32'h0AA);
        queue_word(8'h5A);
        queue_word(8'h03);
        pulse_start(1'b1);
        wait_done(300);
        finish_load(32'h35A, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
